// File: rtl/amp_detect.sv
`timescale 1ns/1ps
// amp_detect: windowed amplitude detector for an 8-bit unsigned waveform.
//
// When gate rises the block discards SETTLE samples, then measures back-to-back windows of
// win_len samples (0 and 1 are treated as 2). At the end of each window the maximum, minimum,
// peak-to-peak, midpoint and a flat flag are registered together and valid pulses for one
// cycle. Dropping gate aborts the current window without updating the results.
//
// Ports:
//   clk       sampling clock, one wave_in sample per rising edge
//   rst_n     asynchronous active-low reset
//   gate      measurement enable, high = measure continuously
//   wave_in   unsigned waveform sample
//   win_len   window length in samples, latched at each window start
//   amplitude window maximum, zero-extended to 16 bits
//   vmin      window minimum
//   vpp       window maximum minus window minimum
//   mid       (max + min) >> 1
//   flat      vpp < MIN_SWING
//   valid     one-cycle pulse when the result outputs update
//   busy      high while settling or measuring
module amp_detect #(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned MIN_SWING = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gate,
    input  logic [7:0]  wave_in,
    input  logic [15:0] win_len,
    output logic [15:0] amplitude,
    output logic [7:0]  vmin,
    output logic [7:0]  vpp,
    output logic [7:0]  mid,
    output logic        flat,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StSettle, StMeas} state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] settle_cnt;
    logic [15:0] samp_cnt;
    logic [15:0] win_lat;
    logic [7:0]  cur_max;
    logic [7:0]  cur_min;

    // Strobes decoded from the FSM for the datapath.
    logic        clear_settle;
    logic        enter_meas;
    logic        accumulate;
    logic        complete;

    logic [15:0] lat_len;
    logic [7:0]  samp_max;
    logic [7:0]  samp_min;
    logic [7:0]  swing;
    logic [7:0]  mid_val;
    logic        settle_done;
    logic        win_last;

    // Window length with the degenerate lengths 0 and 1 promoted to 2.
    assign lat_len  = (win_len < 16'd2) ? 16'd2 : win_len;

    // Accumulator values including the current sample, so the final sample of a window
    // is folded into the registered result at the same edge.
    assign samp_max = (wave_in > cur_max) ? wave_in : cur_max;
    assign samp_min = (wave_in < cur_min) ? wave_in : cur_min;
    assign swing    = samp_max - samp_min;
    // 9-bit sum so 255 + 255 gives a midpoint of 255.
    assign mid_val  = 8'(({1'b0, samp_max} + {1'b0, samp_min}) >> 1);

    assign settle_done = (32'(settle_cnt) + 32'd1) >= SETTLE;
    assign win_last    = (samp_cnt == (win_lat - 16'd1));

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        clear_settle = 1'b0;
        enter_meas   = 1'b0;
        accumulate   = 1'b0;
        complete     = 1'b0;
        unique case (state)
            StIdle: begin
                if (gate) begin
                    next_state   = StSettle;
                    clear_settle = 1'b1;
                end
            end
            StSettle: begin
                if (!gate) begin
                    next_state = StIdle;
                end else if (settle_done) begin
                    next_state = StMeas;
                    enter_meas = 1'b1;
                end
            end
            StMeas: begin
                // Gate low wins over window completion: nothing is committed.
                if (!gate) begin
                    next_state = StIdle;
                end else if (win_last) begin
                    complete = 1'b1;
                end else begin
                    accumulate = 1'b1;
                end
            end
            default: begin
                next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 16'd0;
            samp_cnt   <= 16'd0;
            win_lat    <= 16'd2;
            cur_max    <= 8'd0;
            cur_min    <= 8'd255;
            amplitude  <= 16'd0;
            vmin       <= 8'd0;
            vpp        <= 8'd0;
            mid        <= 8'd0;
            flat       <= 1'b1;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear_settle) begin
                settle_cnt <= 16'd0;
            end else if (state == StSettle) begin
                settle_cnt <= settle_cnt + 16'd1;
            end

            if (enter_meas || complete) begin
                // Window start: fresh accumulators and a newly latched length.
                win_lat  <= lat_len;
                cur_max  <= 8'd0;
                cur_min  <= 8'd255;
                samp_cnt <= 16'd0;
            end else if (accumulate) begin
                cur_max  <= samp_max;
                cur_min  <= samp_min;
                samp_cnt <= samp_cnt + 16'd1;
            end

            if (complete) begin
                amplitude <= {8'd0, samp_max};
                vmin      <= samp_min;
                vpp       <= swing;
                mid       <= mid_val;
                flat      <= (32'(swing) < MIN_SWING);
                valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_amp_detect.sv
`timescale 1ns/1ps
// Directed bench for amp_detect with default parameters (SETTLE=4, MIN_SWING=8).
// Each scenario counts edges from the gate edge E0; with SETTLE=4 a window of N samples
// completes at edge 4+N.
module tb_amp_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gate = 1'b0;
    logic [7:0]  wave_in = 8'd0;
    logic [15:0] win_len = 16'd16;
    logic [15:0] amplitude;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
    logic [7:0]  mid;
    logic        flat;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    amp_detect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gate      (gate),
        .wave_in   (wave_in),
        .win_len   (win_len),
        .amplitude (amplitude),
        .vmin      (vmin),
        .vpp       (vpp),
        .mid       (mid),
        .flat      (flat),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stop_gate();
        gate = 1'b0;
        tick();
        tick();
    endtask

    // Raise gate and take edge E0.
    task automatic start_gate();
        gate = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        gate    = 1'b1;
        win_len = 16'd16;
        for (int i = 0; i < 10; i++) begin
            wave_in = 8'($urandom);
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cycle %0d got %0b want 0", i, valid);
            end
        end
        checks++;
        if (amplitude !== 16'd0) begin
            errors++; $display("FAIL reset_amplitude got %0d want 0", amplitude);
        end
        checks++;
        if (vmin !== 8'd0) begin errors++; $display("FAIL reset_vmin got %0d want 0", vmin); end
        checks++;
        if (vpp !== 8'd0) begin errors++; $display("FAIL reset_vpp got %0d want 0", vpp); end
        checks++;
        if (mid !== 8'd0) begin errors++; $display("FAIL reset_mid got %0d want 0", mid); end
        checks++;
        if (flat !== 1'b1) begin errors++; $display("FAIL reset_flat got %0b want 1", flat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        gate  = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_ramp();
        logic exp_v;
        win_len = 16'd256;
        wave_in = 8'd0;
        start_gate();
        for (int k = 1; k <= 516; k++) begin
            wave_in = 8'(k);
            tick();
            exp_v = (k == 260) || (k == 516);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL ramp_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got %0b want 1", busy); end
            end
            if (k == 260) begin
                checks++;
                if (amplitude !== 16'd255) begin
                    errors++; $display("FAIL ramp_amplitude got %0d want 255", amplitude);
                end
                checks++;
                if (vmin !== 8'd0) begin errors++; $display("FAIL ramp_vmin got %0d want 0", vmin); end
                checks++;
                if (vpp !== 8'd255) begin errors++; $display("FAIL ramp_vpp got %0d want 255", vpp); end
                checks++;
                if (mid !== 8'd127) begin errors++; $display("FAIL ramp_mid got %0d want 127", mid); end
                checks++;
                if (flat !== 1'b0) begin errors++; $display("FAIL ramp_flat got %0b want 0", flat); end
            end
        end
    endtask

    task automatic test_square();
        logic exp_v;
        stop_gate();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
        checks++;
        if (amplitude !== 16'd255) begin
            errors++; $display("FAIL idle_hold_amplitude got %0d want 255", amplitude);
        end
        win_len = 16'd512;
        wave_in = 8'd217;
        start_gate();
        for (int k = 1; k <= 516; k++) begin
            wave_in = (((k / 8) % 2) != 0) ? 8'd39 : 8'd217;
            tick();
            exp_v = (k == 516);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL square_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
            if (k == 515) begin
                checks++;
                if (amplitude !== 16'd255) begin
                    errors++; $display("FAIL square_partial amplitude got %0d want 255", amplitude);
                end
            end
        end
        checks++;
        if (amplitude !== 16'd217) begin
            errors++; $display("FAIL square_amplitude got %0d want 217", amplitude);
        end
        checks++;
        if (vmin !== 8'd39) begin errors++; $display("FAIL square_vmin got %0d want 39", vmin); end
        checks++;
        if (vpp !== 8'd178) begin errors++; $display("FAIL square_vpp got %0d want 178", vpp); end
        checks++;
        if (mid !== 8'd128) begin errors++; $display("FAIL square_mid got %0d want 128", mid); end
        checks++;
        if (flat !== 1'b0) begin errors++; $display("FAIL square_flat got %0b want 0", flat); end
    endtask

    // Constant input, back-to-back windows, and a win_len change that must wait for the
    // next window start (changed during the window ending at 52).
    task automatic test_back_to_back();
        logic exp_v;
        stop_gate();
        win_len = 16'd16;
        wave_in = 8'd128;
        start_gate();
        for (int k = 1; k <= 58; k++) begin
            if (k == 41) win_len = 16'd0;
            tick();
            exp_v = (k == 20) || (k == 36) || (k == 52) || (k == 54) || (k == 56) || (k == 58);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL b2b_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
            if (k == 20) begin
                checks++;
                if (vpp !== 8'd0) begin errors++; $display("FAIL const_vpp got %0d want 0", vpp); end
                checks++;
                if (mid !== 8'd128) begin errors++; $display("FAIL const_mid got %0d want 128", mid); end
                checks++;
                if (flat !== 1'b1) begin errors++; $display("FAIL const_flat got %0b want 1", flat); end
                checks++;
                if (vmin !== 8'd128) begin
                    errors++; $display("FAIL const_vmin got %0d want 128", vmin);
                end
            end
        end
    endtask

    // Two-sample windows: swing 7 vs 8 around the flat threshold, then 255+255 midpoint.
    task automatic test_boundaries();
        logic exp_v;
        stop_gate();
        win_len = 16'd1;
        wave_in = 8'd0;
        start_gate();
        for (int k = 1; k <= 10; k++) begin
            case (k)
                5: wave_in = 8'd100;
                6: wave_in = 8'd107;
                7: wave_in = 8'd100;
                8: wave_in = 8'd108;
                9, 10: wave_in = 8'd255;
                default: wave_in = 8'd0;
            endcase
            tick();
            exp_v = (k == 6) || (k == 8) || (k == 10);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL bound_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
            if (k == 6) begin
                checks++;
                if (vpp !== 8'd7 || flat !== 1'b1 || mid !== 8'd103 || amplitude !== 16'd107) begin
                    errors++;
                    $display("FAIL swing7 got vpp=%0d flat=%0b mid=%0d amp=%0d want 7 1 103 107",
                             vpp, flat, mid, amplitude);
                end
            end
            if (k == 8) begin
                checks++;
                if (vpp !== 8'd8 || flat !== 1'b0 || mid !== 8'd104 || vmin !== 8'd100) begin
                    errors++;
                    $display("FAIL swing8 got vpp=%0d flat=%0b mid=%0d vmin=%0d want 8 0 104 100",
                             vpp, flat, mid, vmin);
                end
            end
            if (k == 10) begin
                checks++;
                if (mid !== 8'd255 || vpp !== 8'd0 || amplitude !== 16'd255 || vmin !== 8'd255) begin
                    errors++;
                    $display("FAIL mid_max got mid=%0d vpp=%0d amp=%0d vmin=%0d want 255 0 255 255",
                             mid, vpp, amplitude, vmin);
                end
            end
        end
    endtask

    task automatic test_gate_abort();
        logic exp_v;
        stop_gate();
        win_len = 16'd256;
        wave_in = 8'd0;
        start_gate();
        // First window completes at 260; the next is aborted after 100 samples.
        for (int k = 1; k <= 360; k++) begin
            wave_in = 8'(k);
            tick();
            exp_v = (k == 260);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL abort_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
        end
        gate = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++; $display("FAIL abort_novalid cycle %0d got %0b want 0", i, valid);
            end
        end
        checks++;
        if (amplitude !== 16'd255 || vmin !== 8'd0 || vpp !== 8'd255 || mid !== 8'd127
            || flat !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold got amp=%0d vmin=%0d vpp=%0d mid=%0d flat=%0b busy=%0b want 255 0 255 127 0 0",
                     amplitude, vmin, vpp, mid, flat, busy);
        end
        start_gate();
        for (int k = 1; k <= 260; k++) begin
            wave_in = 8'(k + 40);
            tick();
            exp_v = (k == 260);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL regate_valid edge %0d got %0b want %0b", k, valid, exp_v);
            end
        end
    endtask

    task automatic test_gate_at_completion();
        stop_gate();
        win_len = 16'd4;
        wave_in = 8'd60;
        start_gate();
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++; $display("FAIL coinc_pre edge %0d got %0b want 0", k, valid);
            end
        end
        gate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++; $display("FAIL coinc_valid cycle %0d got %0b want 0", i, valid);
            end
        end
        checks++;
        if (amplitude !== 16'd255 || busy !== 1'b0) begin
            errors++;
            $display("FAIL coinc_hold got amp=%0d busy=%0b want 255 0", amplitude, busy);
        end
        start_gate();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (valid !== (k == 8)) begin
                errors++; $display("FAIL coinc_retry edge %0d got %0b want %0b", k, valid, (k == 8));
            end
        end
        checks++;
        if (amplitude !== 16'd60 || vmin !== 8'd60 || mid !== 8'd60) begin
            errors++;
            $display("FAIL coinc_result got amp=%0d vmin=%0d mid=%0d want 60 60 60", amplitude, vmin, mid);
        end
    endtask

    task automatic test_async_reset();
        logic exp_v;
        stop_gate();
        win_len = 16'd256;
        wave_in = 8'd0;
        start_gate();
        for (int k = 1; k <= 54; k++) begin
            wave_in = 8'(k);
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++; $display("FAIL arst_pre edge %0d got %0b want 0", k, valid);
            end
        end
        // Assert reset mid-cycle, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (amplitude !== 16'd0 || vmin !== 8'd0 || vpp !== 8'd0 || mid !== 8'd0
            || flat !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear got amp=%0d vmin=%0d vpp=%0d mid=%0d flat=%0b valid=%0b busy=%0b",
                     amplitude, vmin, vpp, mid, flat, valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL arst_hold cycle %0d got valid=%0b busy=%0b want 0 0", i, valid, busy);
            end
        end
        rst_n   = 1'b1;
        wave_in = 8'd0;
        tick();
        for (int k = 1; k <= 260; k++) begin
            wave_in = 8'(k);
            tick();
            exp_v = (k == 260);
            checks++;
            if (valid !== exp_v) begin
                errors++; $display("FAIL arst_after edge %0d got %0b want %0b", k, valid, exp_v);
            end
        end
        checks++;
        if (amplitude !== 16'd255 || vmin !== 8'd0 || mid !== 8'd127) begin
            errors++;
            $display("FAIL arst_result got amp=%0d vmin=%0d mid=%0d want 255 0 127", amplitude, vmin, mid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_square();
        test_back_to_back();
        test_boundaries();
        test_gate_abort();
        test_gate_at_completion();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amp_detect.md
AMP_DETECT -- requirements
Module: amp_detect

Interface
REQ-001 Parameter SETTLE, default 4: samples discarded after gate rises, before the first window.
REQ-002 Parameter MIN_SWING, default 8: peak-to-peak threshold below which flat is raised.
REQ-003 The block SHALL have one clock, clk. Reset rst_n SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1, sampling clock; one wave_in sample per rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port gate, input, 1, measurement enable; high = measure continuously.
REQ-007 Port wave_in, input, 8, unsigned waveform sample.
REQ-008 Port win_len, input, 16, window length in samples.
REQ-009 Port amplitude, output, 16, window maximum zero-extended; feeds the duty/phase stages downstream.
REQ-010 Port vmin, output, 8, window minimum.
REQ-011 Port vpp, output, 8, window maximum minus window minimum.
REQ-012 Port mid, output, 8, midpoint (max+min)>>1.
REQ-013 Port flat, output, 1, high when vpp < MIN_SWING.
REQ-014 Port valid, output, 1, one-cycle pulse when the result outputs update.
REQ-015 Port busy, output, 1, high in the SETTLE and MEAS states.

Function
REQ-016 The FSM SHALL have three states: IDLE, SETTLE and MEAS.
REQ-017 In IDLE with gate=1, the FSM SHALL go to SETTLE, clear the settle counter, and take no sample that cycle.
REQ-018 SETTLE SHALL discard exactly SETTLE samples, then go to MEAS; if SETTLE=0, it goes to MEAS on the next edge.
REQ-019 On entry to MEAS, the block SHALL latch the window length, load cur_max=0 and cur_min=255, and clear the sample counter.
REQ-020 The latched window length SHALL be win_len, except that values 0 and 1 are treated as 2.
REQ-021 Each MEAS cycle SHALL sample wave_in: cur_max <= max(cur_max, wave_in), cur_min <= min(cur_min, wave_in), counter increments.
REQ-022 At the edge that samples the Nth window sample, results SHALL be computed including that sample and registered.
REQ-023 At that same edge, valid SHALL go high for exactly the following cycle.
REQ-024 At that same edge, the accumulators SHALL be reloaded (0/255), the counter cleared, and win_len re-latched; the state stays MEAS and windows run back-to-back with no gap.
REQ-025 A change to win_len during a window SHALL take effect only at the next window start.
REQ-026 mid SHALL use a 9-bit sum, so there is no overflow (255+255 gives mid=255).
REQ-027 vpp SHALL be computed as max-min, which never underflows because max >= min within a window.
REQ-028 If gate falls in any state, the FSM SHALL go to IDLE on that edge and discard the partial window with no valid.
REQ-029 Result outputs SHALL hold their last values while in IDLE.
REQ-030 If gate falls on the same edge as window completion, gate low SHALL win: no valid, and outputs are not updated.
REQ-031 When gate rises again, the block SHALL restart from SETTLE.
REQ-032 Outputs SHALL change only at window completion and SHALL never show partial-window values.

Reset
REQ-033 When rst_n=0, the block SHALL immediately set: state IDLE, amplitude=0, vmin=0, vpp=0, mid=0, flat=1, valid=0, busy=0, counters 0, accumulators 0/255.
REQ-034 Assertion of rst_n mid-window SHALL discard the window with no valid; on release, the block waits in IDLE until gate=1.

Verification
REQ-035 Reset: hold rst_n=0 with random wave_in and gate=1 -> all outputs at REQ-033 values, and valid is never high.
REQ-036 Ramp: wave_in 0..255 repeating, win_len=256, gate high -> first valid 4+256 cycles after the gate edge; amplitude=255, vmin=0, vpp=255, mid=127, flat=0; then valid every 256 cycles.
REQ-037 Square from the sqr LUT at amplitude 217 (levels 217/39), win_len=512 -> amplitude=217, vmin=39, vpp=178, mid=128, flat=0.
REQ-038 Constant 128, win_len=16 -> vpp=0, mid=128, flat=1, valid every 16 cycles; win_len=0 -> valid every 2 cycles.
REQ-039 Gate abort: gate drops after 100 of 256 samples -> no valid, outputs keep the prior window values; gate re-raised -> next valid after 4+256 cycles.
REQ-040 Async reset mid-window (sample 50 of 256) -> outputs cleared in the same cycle, no valid; after release with gate high, a full SETTLE plus window precedes the next valid.
